sw_pe_affine: RTL and testbench

// Parametrised Smith-Waterman systolic PE with affine gap penalties (open/extend).
// - Holds one query char X; database chars Y stream through one PE per cycle.
// - Computes H/E/F per column; tracks per-stream best score and its column.
// - Chained PE[i-1] -> PE[i] in the systolic array. Multi-stream capable: last_i closes a stream.

---
 rtl/sw_pe_affine.sv | 155 +++++++++++++++
 tb/tb_sw_pe_affine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_pe_affine.sv
// sw_pe_affine -- one processing element of a Smith-Waterman systolic array
// with affine gap penalties (separate open and extend costs).
//
// The PE holds one query character (xq) and scores it against a stream of
// database characters Y that pass through one PE per cycle. For each column
// it produces H (local alignment score), E (horizontal gap) and F (vertical
// gap). It also tracks the best H of the current stream and the column where
// that best score first occurred. A beat flagged with last_i closes the
// stream and clears the column state, ready for the next stream.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   load_x_i, X_i        load the query character (applies from the next beat)
//   Y_i, valid_i, last_i streaming database beat
//   top_i, F_i           H(i-1,j) and F(i-1,j) from the upstream PE
//   score_o, F_o         H(i,j) and F(i,j) for the downstream PE
//   Y_o, valid_o, last_o beat forwarded downstream (one cycle later)
//   max_o, max_pos_o     best H of the current stream and its first column
module sw_pe_affine #(
  parameter int SCORE_W  = 16,
  parameter int CHAR_W   = 2,
  parameter int POS_W    = 16,
  parameter int MATCH    = 2,
  parameter int MISMATCH = 1,
  parameter int GAP_OPEN = 2,
  parameter int GAP_EXT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_x_i,
  input  logic [CHAR_W-1:0]  X_i,
  input  logic [CHAR_W-1:0]  Y_i,
  input  logic               valid_i,
  input  logic               last_i,
  input  logic [SCORE_W-1:0] top_i,
  input  logic [SCORE_W-1:0] F_i,
  output logic [SCORE_W-1:0] score_o,
  output logic [SCORE_W-1:0] F_o,
  output logic [CHAR_W-1:0]  Y_o,
  output logic               valid_o,
  output logic               last_o,
  output logic [SCORE_W-1:0] max_o,
  output logic [POS_W-1:0]   max_pos_o
);

  // Two guard bits hold diag+MATCH before it is clamped back to SCORE_W.
  localparam int CW = SCORE_W + 2;
  typedef logic [CW-1:0] wide_t;

  localparam wide_t SAT_W      = {2'b00, {SCORE_W{1'b1}}};
  localparam wide_t MATCH_W    = wide_t'(MATCH);
  localparam wide_t MISMATCH_W = wide_t'(MISMATCH);
  localparam wide_t GAP_OPEN_W = wide_t'(GAP_OPEN);
  localparam wide_t GAP_EXT_W  = wide_t'(GAP_EXT);

  // Floor-at-zero subtraction: scores are unsigned and never go negative.
  function automatic wide_t sub_z(input wide_t a, input wide_t b);
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic wide_t max2(input wide_t a, input wide_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic wide_t sat(input wide_t a);
    return (a > SAT_W) ? SAT_W : a;
  endfunction

  // Per-stream state.
  logic [CHAR_W-1:0]  xq_reg;
  logic [SCORE_W-1:0] diag_reg;
  logic [SCORE_W-1:0] h_prev_reg;
  logic [SCORE_W-1:0] e_prev_reg;
  logic [POS_W-1:0]   col_reg;
  logic               first_reg;

  wide_t s_next;
  wide_t e_next;
  wide_t f_next;
  wide_t h_next;

  always_comb begin
    s_next = '0;
    e_next = '0;
    f_next = '0;
    h_next = '0;
    if (xq_reg == Y_i) begin
      s_next = sat({2'b00, diag_reg} + MATCH_W);
    end else begin
      s_next = sub_z({2'b00, diag_reg}, MISMATCH_W);
    end
    e_next = sat(max2(sub_z({2'b00, e_prev_reg}, GAP_EXT_W),
                      sub_z({2'b00, h_prev_reg}, GAP_OPEN_W)));
    f_next = sat(max2(sub_z({2'b00, F_i}, GAP_EXT_W),
                      sub_z({2'b00, top_i}, GAP_OPEN_W)));
    // The zero floor of local alignment is implicit: every term is unsigned.
    h_next = sat(max2(s_next, max2(e_next, f_next)));
  end

  logic [SCORE_W-1:0] h_trunc;
  logic [SCORE_W-1:0] e_trunc;
  logic [SCORE_W-1:0] f_trunc;
  assign h_trunc = h_next[SCORE_W-1:0];
  assign e_trunc = e_next[SCORE_W-1:0];
  assign f_trunc = f_next[SCORE_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      xq_reg     <= '0;
      diag_reg   <= '0;
      h_prev_reg <= '0;
      e_prev_reg <= '0;
      col_reg    <= '0;
      first_reg  <= 1'b1;
      score_o    <= '0;
      F_o        <= '0;
      Y_o        <= '0;
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      max_o      <= '0;
      max_pos_o  <= '0;
    end else begin
      // A beat in the same cycle as a load still scores against the old xq.
      if (load_x_i) begin
        xq_reg <= X_i;
      end
      valid_o <= valid_i;
      last_o  <= valid_i & last_i;
      if (valid_i) begin
        score_o <= h_trunc;
        F_o     <= f_trunc;
        Y_o     <= Y_i;
        // Strict compare keeps the earliest column on ties.
        if (first_reg || (h_trunc > max_o)) begin
          max_o     <= h_trunc;
          max_pos_o <= col_reg;
        end
        if (last_i) begin
          diag_reg   <= '0;
          h_prev_reg <= '0;
          e_prev_reg <= '0;
          col_reg    <= '0;
          first_reg  <= 1'b1;
        end else begin
          diag_reg   <= top_i;
          h_prev_reg <= h_trunc;
          e_prev_reg <= e_trunc;
          col_reg    <= col_reg + POS_W'(1);
          first_reg  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_pe_affine.sv
// tb_sw_pe_affine -- directed bench for sw_pe_affine. A default-width PE
// covers scoring, gaps, bubbles, stream restart, ties, query loading and
// reset; a 4-bit-score PE covers saturation.
module tb_sw_pe_affine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        load_x;
  logic [1:0]  x;
  logic [1:0]  y;
  logic        valid;
  logic        last;
  logic [15:0] top;
  logic [15:0] fin;
  logic [15:0] score;
  logic [15:0] fo;
  logic [1:0]  yo;
  logic        vo;
  logic        lo;
  logic [15:0] mx;
  logic [15:0] mxpos;

  logic [1:0]  y4;
  logic        valid4;
  logic        last4;
  logic [3:0]  top4;
  logic [3:0]  f4;
  logic [3:0]  score4;
  logic [3:0]  fo4;
  logic [1:0]  yo4;
  logic        vo4;
  logic        lo4;
  logic [3:0]  mx4;
  logic [15:0] pos4;

  int checks = 0;
  int errors = 0;

  sw_pe_affine dut (
    .clk(clk), .rst(rst), .load_x_i(load_x), .X_i(x), .Y_i(y),
    .valid_i(valid), .last_i(last), .top_i(top), .F_i(fin),
    .score_o(score), .F_o(fo), .Y_o(yo), .valid_o(vo), .last_o(lo),
    .max_o(mx), .max_pos_o(mxpos)
  );

  sw_pe_affine #(.SCORE_W(4)) dut4 (
    .clk(clk), .rst(rst), .load_x_i(load_x), .X_i(x), .Y_i(y4),
    .valid_i(valid4), .last_i(last4), .top_i(top4), .F_i(f4),
    .score_o(score4), .F_o(fo4), .Y_o(yo4), .valid_o(vo4), .last_o(lo4),
    .max_o(mx4), .max_pos_o(pos4)
  );

  // One beat into the default PE; returns 1 time unit after the edge.
  task automatic beat(input logic [1:0] by, input logic [15:0] btop,
                      input logic [15:0] bf, input logic bl);
    y = by; top = btop; fin = bf; last = bl; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; last = 1'b0;
    $display("beat y=%0d top=%0d f=%0d last=%0d -> score=%0d F=%0d valid=%0d last=%0d max=%0d pos=%0d",
             by, btop, bf, bl, score, fo, vo, lo, mx, mxpos);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; y = 2'd1; top = 16'd9; last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({score, fo, yo, vo, lo, mx, mxpos} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got score=%0d F=%0d Y=%0d v=%0d l=%0d max=%0d pos=%0d, want all 0",
               score, fo, yo, vo, lo, mx, mxpos);
    end
    rst = 1'b0; valid = 1'b0; last = 1'b0; top = '0; y = '0;
    $display("reset done");
  endtask

  task automatic test_t1();
    beat(2'd0, 16'd0, 16'd0, 1'b1);
    checks++;
    if (score !== 16'd2 || fo !== 16'd0 || mx !== 16'd2 || mxpos !== 16'd0 ||
        lo !== 1'b1 || vo !== 1'b1) begin
      errors++;
      $display("FAIL t1_single: got score=%0d F=%0d max=%0d pos=%0d l=%0d v=%0d, want 2 0 2 0 1 1",
               score, fo, mx, mxpos, lo, vo);
    end
  endtask

  // T2 stream, optionally with a bubble after each beat.
  task automatic run_t2(input string name, input bit bubbles);
    logic [15:0] tops [3];
    logic [15:0] exp_s [3];
    logic [15:0] exp_f [3];
    tops  = '{16'd9, 16'd0, 16'd0};
    exp_s = '{16'd7, 16'd8, 16'd6};
    exp_f = '{16'd7, 16'd0, 16'd0};
    for (int i = 0; i < 3; i++) begin
      beat(2'd1, tops[i], 16'd0, i == 2);
      checks++;
      if (score !== exp_s[i] || fo !== exp_f[i] || yo !== 2'd1 || vo !== 1'b1 ||
          lo !== (i == 2)) begin
        errors++;
        $display("FAIL %s_beat%0d: got score=%0d F=%0d Y=%0d v=%0d l=%0d, want %0d %0d 1 1 %0d",
                 name, i, score, fo, yo, vo, lo, exp_s[i], exp_f[i], i == 2);
      end
      if (bubbles) begin
        idle();
        checks++;
        if (vo !== 1'b0 || lo !== 1'b0 || score !== exp_s[i] || fo !== exp_f[i]) begin
          errors++;
          $display("FAIL %s_bubble%0d: got v=%0d l=%0d score=%0d F=%0d, want 0 0 %0d %0d",
                   name, i, vo, lo, score, fo, exp_s[i], exp_f[i]);
        end
        $display("bubble after beat %0d", i);
      end
    end
    checks++;
    if (mx !== 16'd8 || mxpos !== 16'd1) begin
      errors++;
      $display("FAIL %s_max: got max=%0d pos=%0d, want 8 1", name, mx, mxpos);
    end
  endtask

  task automatic test_t2();
    run_t2("t2", 1'b0);
    // Results must hold through idle cycles after the stream closes.
    idle(); idle();
    checks++;
    if (mx !== 16'd8 || mxpos !== 16'd1 || vo !== 1'b0) begin
      errors++;
      $display("FAIL t2_hold: got max=%0d pos=%0d v=%0d, want 8 1 0", mx, mxpos, vo);
    end
  endtask

  task automatic test_bubbles();
    run_t2("t3", 1'b1);
  endtask

  task automatic test_back_to_back();
    run_t2("t4a", 1'b0);
    test_t1();
  endtask

  // Equal score in a later column must not move max_pos_o.
  task automatic test_tie();
    beat(2'd0, 16'd0, 16'd0, 1'b0);
    beat(2'd1, 16'd4, 16'd0, 1'b1);
    checks++;
    if (score !== 16'd2 || mx !== 16'd2 || mxpos !== 16'd0) begin
      errors++;
      $display("FAIL tie_first: got score=%0d max=%0d pos=%0d, want 2 2 0", score, mx, mxpos);
    end
  endtask

  task automatic test_load_x();
    // Load X=1 in the same cycle as a Y=1 beat: that beat still sees xq=0.
    load_x = 1'b1; x = 2'd1;
    beat(2'd1, 16'd0, 16'd0, 1'b0);
    load_x = 1'b0;
    checks++;
    if (score !== 16'd0) begin
      errors++;
      $display("FAIL loadx_old: got score=%0d, want 0", score);
    end
    beat(2'd1, 16'd0, 16'd0, 1'b1);
    checks++;
    if (score !== 16'd2 || mx !== 16'd2 || mxpos !== 16'd1) begin
      errors++;
      $display("FAIL loadx_new: got score=%0d max=%0d pos=%0d, want 2 2 1", score, mx, mxpos);
    end
    load_x = 1'b1; x = 2'd0;
    idle();
    load_x = 1'b0;
  endtask

  task automatic test_saturation();
    y4 = 2'd0; top4 = 4'd15; f4 = 4'd0; last4 = 1'b0; valid4 = 1'b1;
    @(posedge clk); #1;
    $display("sat beat0 -> score=%0d", score4);
    checks++;
    if (score4 !== 4'd13 || fo4 !== 4'd13) begin
      errors++;
      $display("FAIL sat_beat0: got score=%0d F=%0d, want 13 13", score4, fo4);
    end
    last4 = 1'b1;
    @(posedge clk); #1;
    valid4 = 1'b0; last4 = 1'b0;
    $display("sat beat1 -> score=%0d max=%0d pos=%0d", score4, mx4, pos4);
    checks++;
    if (score4 !== 4'd15 || mx4 !== 4'd15 || pos4 !== 16'd1 || lo4 !== 1'b1) begin
      errors++;
      $display("FAIL sat_beat1: got score=%0d max=%0d pos=%0d l=%0d, want 15 15 1 1",
               score4, mx4, pos4, lo4);
    end
  endtask

  task automatic test_mid_reset();
    beat(2'd1, 16'd9, 16'd0, 1'b0);
    beat(2'd1, 16'd0, 16'd0, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checks++;
    if ({score, fo, yo, vo, lo, mx, mxpos} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got score=%0d F=%0d Y=%0d v=%0d l=%0d max=%0d pos=%0d, want all 0",
               score, fo, yo, vo, lo, mx, mxpos);
    end
    run_t2("t6", 1'b0);
  endtask

  initial begin
    rst = 1'b1; load_x = 1'b0; x = '0; y = '0; valid = 1'b0; last = 1'b0;
    top = '0; fin = '0;
    y4 = '0; valid4 = 1'b0; last4 = 1'b0; top4 = '0; f4 = '0;
    test_reset();
    load_x = 1'b1; x = 2'd0;
    idle();
    load_x = 1'b0;
    test_t1();
    idle();
    test_t2();
    test_bubbles();
    idle();
    test_back_to_back();
    idle();
    test_tie();
    test_load_x();
    test_saturation();
    test_mid_reset();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
